// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the line-granular memory arbiter.
package mem_arb_pkg;

  // Arbiter transaction state: idle, one of three busy kinds, one-cycle response.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVICT = 3'd1,
    DREAD = 3'd2,
    IREAD = 3'd3,
    RESP  = 3'd4
  } arb_state_t;

  // Byte-offset bits inside a 64-byte line.
  localparam int LINE_OFFSET_W  = 6;
  localparam int DEFAULT_LINE_W = 512;
  localparam int DEFAULT_ADDR_W = 32;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating cycle counter with enable and clear; raises a sticky flag once
// the count reaches TIMEOUT. The flag only clears on reset.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic flag
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT_M = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  // Count stalled request cycles, saturating at TIMEOUT; clear between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && count_reg != LIMIT) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Flag sets on the same edge the count reaches TIMEOUT and then sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else if (!clr && en && count_reg >= LIMIT_M) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: serves I-cache refills, D-cache refills and D-cache
// evictions one 512-bit line at a time over a single memory port, and
// yields the port to the FFT engine while fftCalculating is high.
// Optional feature: define MEMARB_FAIR_EN to alternate DREAD/IREAD priority
// when both are pending (EVICT always wins).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int LINE_W  = DEFAULT_LINE_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cacheMissFetch,
  input  logic [ADDR_W-1:0] instrAddr,
  input  logic              cacheMissMemory,
  input  logic              dCacheEvict,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [ADDR_W-1:0] evictAddr,
  input  logic [LINE_W-1:0] dCacheOut,
  input  logic              fftCalculating,
  output logic              mcInstrValid,
  output logic [LINE_W-1:0] mcInstrIn,
  output logic              mcDataValid,
  output logic [LINE_W-1:0] mcDataIn,
  output logic              evictDone,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [LINE_W-1:0] memWdata,
  input  logic              memAck,
  input  logic [LINE_W-1:0] memRdata,
  output logic              memTimeout
);

  localparam logic [ADDR_W-1:0] LINE_MASK =
    {{(ADDR_W - LINE_OFFSET_W){1'b1}}, {LINE_OFFSET_W{1'b0}}};

  arb_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] grant_addr;
  logic              prefer_d;
  logic              busy;
  logic              ack_taken;
  logic              granting;

`ifdef MEMARB_FAIR_EN
  logic last_d_reg;

  // Remember whether the most recent read grant was a D-cache refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_reg <= 1'b0;
    end else if (granting && state_next == DREAD) begin
      last_d_reg <= 1'b1;
    end else if (granting && state_next == IREAD) begin
      last_d_reg <= 1'b0;
    end
  end

  // D wins unless I is also waiting and D had the previous read.
  assign prefer_d = cacheMissMemory && !(cacheMissFetch && last_d_reg);
`else
  assign prefer_d = cacheMissMemory;
`endif

  assign busy      = (state_reg == EVICT) || (state_reg == DREAD) || (state_reg == IREAD);
  assign ack_taken = busy && memReq && memAck;
  assign granting  = (state_reg == IDLE) && (state_next != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and grant selection.
  always_comb begin
    state_next = state_reg;
    grant_addr = instrAddr;
    case (state_reg)
      IDLE: begin
        if (!fftCalculating) begin
          if (dCacheEvict) begin
            state_next = EVICT;
            grant_addr = evictAddr;
          end else if (prefer_d) begin
            state_next = DREAD;
            grant_addr = dAddr;
          end else if (cacheMissFetch) begin
            state_next = IREAD;
            grant_addr = instrAddr;
          end
        end
      end
      EVICT, DREAD, IREAD: begin
        if (ack_taken) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side request registers and CPU-side response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memReq       <= 1'b0;
      memWe        <= 1'b0;
      memAddr      <= '0;
      memWdata     <= '0;
      mcInstrValid <= 1'b0;
      mcInstrIn    <= '0;
      mcDataValid  <= 1'b0;
      mcDataIn     <= '0;
      evictDone    <= 1'b0;
    end else begin
      mcInstrValid <= 1'b0;
      mcDataValid  <= 1'b0;
      evictDone    <= 1'b0;
      if (granting) begin
        memReq  <= 1'b1;
        memWe   <= (state_next == EVICT);
        memAddr <= grant_addr & LINE_MASK;
        if (state_next == EVICT) memWdata <= dCacheOut;
      end
      if (ack_taken) begin
        memReq <= 1'b0;
        case (state_reg)
          EVICT: evictDone <= 1'b1;
          DREAD: begin
            mcDataIn    <= memRdata;
            mcDataValid <= 1'b1;
          end
          IREAD: begin
            mcInstrIn    <= memRdata;
            mcInstrValid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (memReq & ~memAck),
    .clr  (~memReq),
    .flag (memTimeout)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// request mixes checked against a priority-rule reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 512;
  localparam int TO = 16;
  localparam logic [AW-1:0] AMASK = 32'hFFFF_FFC0;

  // kinds of transaction
  localparam int K_NONE = 0, K_EV = 1, K_D = 2, K_I = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cacheMissFetch, cacheMissMemory, dCacheEvict, fftCalculating;
  logic [AW-1:0] instrAddr, dAddr, evictAddr;
  logic [LW-1:0] dCacheOut;
  logic          mcInstrValid, mcDataValid, evictDone;
  logic [LW-1:0] mcInstrIn, mcDataIn;
  logic          memReq, memWe, memAck, memTimeout;
  logic [AW-1:0] memAddr;
  logic [LW-1:0] memWdata, memRdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cacheMissFetch(cacheMissFetch), .instrAddr(instrAddr),
    .cacheMissMemory(cacheMissMemory), .dCacheEvict(dCacheEvict),
    .dAddr(dAddr), .evictAddr(evictAddr), .dCacheOut(dCacheOut),
    .fftCalculating(fftCalculating),
    .mcInstrValid(mcInstrValid), .mcInstrIn(mcInstrIn),
    .mcDataValid(mcDataValid), .mcDataIn(mcDataIn), .evictDone(evictDone),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memAck(memAck), .memRdata(memRdata), .memTimeout(memTimeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit            model_last_d = 1'b0;
  logic [LW-1:0] exp_i_line = '0;
  logic [LW-1:0] exp_d_line = '0;

  // pulse monitors
  int cnt_i = 0, cnt_d = 0, cnt_e = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mcInstrValid) cnt_i++;
      if (mcDataValid)  cnt_d++;
      if (evictDone)    cnt_e++;
    end
  end

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Which request the priority rules pick from the pending set.
  function automatic int pick(bit ev, bit d, bit i, bit last_d);
    if (ev) return K_EV;
`ifdef MEMARB_FAIR_EN
    if (d && i) return last_d ? K_I : K_D;
`endif
    if (d) return K_D;
    if (i) return K_I;
    return K_NONE;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (memReq) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_wait_expired", 1'b0, 1'b1);
  endtask

  // Serve one transaction: check request fields, ack after delay, check response.
  task automatic serve(input string tag, input int delay, input bit drop, output int kind);
    bit            ok;
    logic [AW-1:0] ea;
    logic [LW-1:0] line;
    int            ci, cd, ce;
    kind = pick(dCacheEvict, cacheMissMemory, cacheMissFetch, model_last_d);
    ea = (kind == K_EV) ? evictAddr : (kind == K_D) ? dAddr : instrAddr;
    ea = ea & AMASK;
    wait_req(ok);
    if (!ok) return;
    check({tag, "_addr"}, memAddr, ea);
    check({tag, "_we"}, memWe, kind == K_EV);
    if (kind == K_EV) check({tag, "_wdata"}, memWdata, dCacheOut);
    for (int c = 0; c < delay; c++) step();
    check({tag, "_req_held"}, {memReq, memAddr}, {1'b1, ea});
    ci = cnt_i; cd = cnt_d; ce = cnt_e;
    line = rand_line();
    memRdata = line;
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    if (kind == K_I) exp_i_line = line;
    if (kind == K_D) exp_d_line = line;
    if (kind == K_D) model_last_d = 1'b1;
    if (kind == K_I) model_last_d = 1'b0;
    check({tag, "_pulses"}, {evictDone, mcDataValid, mcInstrValid, memReq},
          {kind == K_EV, kind == K_D, kind == K_I, 1'b0});
    check({tag, "_iline"}, mcInstrIn, exp_i_line);
    check({tag, "_dline"}, mcDataIn, exp_d_line);
    if (drop) begin
      if (kind == K_EV) dCacheEvict = 1'b0;
      if (kind == K_D)  cacheMissMemory = 1'b0;
      if (kind == K_I)  cacheMissFetch = 1'b0;
    end
    step();
    check({tag, "_pulse_once"}, {evictDone, mcDataValid, mcInstrValid}, 3'b000);
    $display("[TB] %s kind=%0d addr=%08h delay=%0d", tag, kind, ea, delay);
    if (ci + ce + cd < 0) check("never", 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctl"}, {memReq, memWe, mcInstrValid, mcDataValid, evictDone, memTimeout}, 6'b0);
    check({tag, "_addr"}, memAddr, '0);
    check({tag, "_wdata"}, memWdata, '0);
    check({tag, "_iline"}, mcInstrIn, '0);
    check({tag, "_dline"}, mcDataIn, '0);
  endtask

  initial begin
    int  kind;
    int  order[4];
    int  p0;
    bit  saw;
    bit  ok;
    logic [LW-1:0] line;

    rst_n = 1'b0;
    cacheMissFetch = 0; cacheMissMemory = 0; dCacheEvict = 0; fftCalculating = 0;
    instrAddr = '0; dAddr = '0; evictAddr = '0; dCacheOut = '0;
    memAck = 0; memRdata = '0;
    repeat (3) step();
    check_reset_state("rst_in");
    rst_n = 1'b1;
    step();
    check_reset_state("rst_out");

    // I-cache refill, ack after 5 cycles
    instrAddr = 32'h0000_1234;
    cacheMissFetch = 1'b1;
    serve("ifetch", 5, 1'b1, kind);

    // dirty miss: evict then read
    evictAddr = 32'h0001_0040;
    dAddr = 32'h0002_0080;
    dCacheOut = rand_line();
    dCacheEvict = 1'b1;
    cacheMissMemory = 1'b1;
    serve("dirty_ev", 2, 1'b1, kind);
    check("dirty_first_evict", kind, K_EV);
    serve("dirty_rd", 1, 1'b1, kind);
    check("dirty_then_dread", kind, K_D);

    // request held through RESP, then dropped: single transaction
    p0 = cnt_i;
    instrAddr = 32'h0000_3FC0;
    cacheMissFetch = 1'b1;
    serve("held", 0, 1'b1, kind);
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (memReq) saw = 1'b1;
    end
    check("held_no_reserve", saw, 1'b0);
    check("held_one_pulse", cnt_i - p0, 1);

    // stray ack while idle is ignored
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    step();
    check("stray_ack", {memReq, mcInstrValid, mcDataValid, evictDone}, 4'b0);

    // fft holds off grants
    fftCalculating = 1'b1;
    dAddr = 32'h0000_8888;
    cacheMissMemory = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (memReq) saw = 1'b1;
    end
    check("fft_hold", saw, 1'b0);
    fftCalculating = 1'b0;
    step();
    check("fft_release_req", memReq, 1'b1);
    // fft rises mid-transaction: transaction completes, then no new grant
    fftCalculating = 1'b1;
    serve("fft_mid", 3, 1'b1, kind);
    instrAddr = 32'h0000_0500;
    cacheMissFetch = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (memReq) saw = 1'b1;
    end
    check("fft_mid_hold", saw, 1'b0);
    fftCalculating = 1'b0;
    serve("fft_after", 0, 1'b1, kind);

    // fairness: both misses held continuously
    dAddr = 32'h0004_0000;
    instrAddr = 32'h0005_0000;
    cacheMissMemory = 1'b1;
    cacheMissFetch = 1'b1;
    for (int t = 0; t < 4; t++) begin
      serve("fair", 0, 1'b0, kind);
      order[t] = kind;
    end
    cacheMissMemory = 1'b0;
    cacheMissFetch = 1'b0;
`ifdef MEMARB_FAIR_EN
    check("fair_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]},
          {2'(K_D), 2'(K_I), 2'(K_D), 2'(K_I)});
`else
    check("fixed_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]},
          {2'(K_D), 2'(K_D), 2'(K_D), 2'(K_D)});
`endif
    step();

    // randomized request mixes
    for (int t = 0; t < 30; t++) begin
      if (!dCacheEvict && $urandom_range(0, 2) == 0) begin
        evictAddr = $urandom();
        dCacheOut = rand_line();
        dCacheEvict = 1'b1;
      end
      if (!cacheMissMemory && $urandom_range(0, 1) == 0) begin
        dAddr = $urandom();
        cacheMissMemory = 1'b1;
      end
      if (!cacheMissFetch && $urandom_range(0, 1) == 0) begin
        instrAddr = $urandom();
        cacheMissFetch = 1'b1;
      end
      if (!dCacheEvict && !cacheMissMemory && !cacheMissFetch) begin
        instrAddr = $urandom();
        cacheMissFetch = 1'b1;
      end
      serve("rand", int'($urandom_range(0, 6)), 1'b1, kind);
    end
    dCacheEvict = 0; cacheMissMemory = 0; cacheMissFetch = 0;
    step();

    // asynchronous reset mid-transaction, request re-served afterwards
    dAddr = 32'h0007_7777;
    cacheMissMemory = 1'b1;
    wait_req(ok);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", memReq, 1'b0);
    model_last_d = 1'b0;
    exp_i_line = '0;
    exp_d_line = '0;
    step();
    check_reset_state("midrst");
    #3 rst_n = 1'b1;
    serve("reserve", 1, 1'b1, kind);
    check("reserve_kind", kind, K_D);

    // watchdog: withheld ack
    check("wd_clear", memTimeout, 1'b0);
    instrAddr = 32'h0000_9000;
    cacheMissFetch = 1'b1;
    wait_req(ok);
    repeat (9) step();
    check("wd_early", memTimeout, 1'b0);
    repeat (8) step();
    check("wd_set", memTimeout, 1'b1);
    line = rand_line();
    memRdata = line;
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    cacheMissFetch = 1'b0;
    check("wd_late_ack", {mcInstrValid, mcInstrIn}, {1'b1, line});
    repeat (3) step();
    check("wd_sticky", memTimeout, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time guard
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
